// File: rtl/muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit for the EX stage, valid/ready on both sides.
// Optional divide-result reuse cache is built when MULDIV_DIV_REUSE_EN is defined.
module muldiv_unit #(
   parameter int XLEN        = 32,
   parameter int MUL_LATENCY = 2,
   parameter int TAG_W       = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;

   logic [1:0]       state_q, state_d, op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d, rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             negq_q, negq_d, negr_q, negr_d;

   logic              accept, d_sgn, a_neg, b_neg, ovf, hit, ma_sgn, mb_sgn;
   logic [XLEN-1:0]   abs_a, abs_b, q_fix, r_fix, mul_res, hit_q, hit_r;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [XLEN:0]     shifted, diff;

   assign accept = req_valid && req_ready && !flush;
   assign d_sgn  = ~req_op[0];
   assign a_neg  = d_sgn & req_a[XLEN-1];
   assign b_neg  = d_sgn & req_b[XLEN-1];
   assign abs_a  = a_neg ? -req_a : req_a;
   assign abs_b  = b_neg ? -req_b : req_b;
   assign ovf    = d_sgn && (req_a == MIN_NEG) && (req_b == '1);

   // Low 2*XLEN bits of the sign-extended product cover every MUL variant.
   assign ma_sgn  = (op_q == 2'b01) || (op_q == 2'b10);
   assign mb_sgn  = (op_q == 2'b01);
   assign mul_a   = {{XLEN{ma_sgn & a_q[XLEN-1]}}, a_q};
   assign mul_b   = {{XLEN{mb_sgn & b_q[XLEN-1]}}, b_q};
   assign prod    = mul_a * mul_b;
   assign mul_res = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign diff    = shifted - {1'b0, dvs_q};
   assign q_fix   = negq_q ? -quo_q : quo_q;
   assign r_fix   = negr_q ? -rem_q : rem_q;

`ifdef MULDIV_DIV_REUSE_EN
   logic            c_vld_q, c_vld_d, c_uns_q, c_uns_d;
   logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d, c_q_q, c_q_d, c_r_q, c_r_d;
   assign hit   = c_vld_q && (req_a == c_a_q) && (req_b == c_b_q) && (req_op[0] == c_uns_q);
   assign hit_q = c_q_q;
   assign hit_r = c_r_q;
`else
   assign hit   = 1'b0;
   assign hit_q = '0;
   assign hit_r = '0;
`endif

   always_comb begin
      state_d = state_q; op_d = op_q; tag_d = tag_q; a_d = a_q; b_d = b_q;
      rem_d = rem_q; quo_d = quo_q; dvs_d = dvs_q; res_d = res_q; cnt_d = cnt_q;
      negq_d = negq_q; negr_d = negr_q;
`ifdef MULDIV_DIV_REUSE_EN
      c_vld_d = c_vld_q; c_uns_d = c_uns_q; c_a_d = c_a_q; c_b_d = c_b_q;
      c_q_d = c_q_q; c_r_d = c_r_q;
`endif
      case (state_q)
         S_IDLE: if (accept) begin
            op_d = req_op[1:0]; tag_d = req_tag; a_d = req_a; b_d = req_b;
            if (!req_op[2]) begin
               state_d = S_MUL;
               cnt_d   = CW'(MUL_LATENCY - 1);
            end else begin
               // Fast cases pass through DIV with cnt=0 so the fixup edge lands one cycle later.
               state_d = S_DIV; cnt_d = '0; negq_d = 1'b0; negr_d = 1'b0;
               rem_d = '0; dvs_d = abs_b;
`ifdef MULDIV_DIV_REUSE_EN
               c_vld_d = hit;
`endif
               if (hit) begin
                  quo_d = hit_q; rem_d = hit_r;
               end else if (req_b == '0) begin
                  quo_d = '1; rem_d = req_a;
               end else if (ovf) begin
                  quo_d = req_a;
               end else begin
                  cnt_d = CW'(XLEN); quo_d = abs_a;
                  negq_d = a_neg ^ b_neg; negr_d = a_neg;
               end
            end
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               res_d = mul_res; state_d = S_DONE;
            end else cnt_d = cnt_q - 1'b1;
         end
         S_DIV: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
               if (!diff[XLEN]) begin
                  rem_d = diff[XLEN-1:0]; quo_d = {quo_q[XLEN-2:0], 1'b1};
               end else begin
                  rem_d = shifted[XLEN-1:0]; quo_d = {quo_q[XLEN-2:0], 1'b0};
               end
            end else begin
               res_d   = op_q[1] ? r_fix : q_fix;
               state_d = S_DONE;
`ifdef MULDIV_DIV_REUSE_EN
               c_vld_d = 1'b1; c_a_d = a_q; c_b_d = b_q; c_uns_d = op_q[0];
               c_q_d = q_fix; c_r_d = r_fix;
`endif
            end
         end
         S_DONE: if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
`ifdef MULDIV_DIV_REUSE_EN
         c_vld_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE; op_q <= '0; tag_q <= '0; a_q <= '0; b_q <= '0;
         rem_q <= '0; quo_q <= '0; dvs_q <= '0; res_q <= '0; cnt_q <= '0;
         negq_q <= 1'b0; negr_q <= 1'b0;
`ifdef MULDIV_DIV_REUSE_EN
         c_vld_q <= 1'b0; c_uns_q <= 1'b0; c_a_q <= '0; c_b_q <= '0; c_q_q <= '0; c_r_q <= '0;
`endif
      end else begin
         state_q <= state_d; op_q <= op_d; tag_q <= tag_d; a_q <= a_d; b_q <= b_d;
         rem_q <= rem_d; quo_q <= quo_d; dvs_q <= dvs_d; res_q <= res_d; cnt_q <= cnt_d;
         negq_q <= negq_d; negr_q <= negr_d;
`ifdef MULDIV_DIV_REUSE_EN
         c_vld_q <= c_vld_d; c_uns_q <= c_uns_d; c_a_q <= c_a_d; c_b_q <= c_b_d;
         c_q_q <= c_q_d; c_r_q <= c_r_d;
`endif
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign resp_valid  = (state_q == S_DONE);
   assign resp_result = res_q;
   assign resp_tag    = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32, MUL_LATENCY=2): directed tables plus random ops vs a reference model.
module tb_muldiv_unit;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, busy;
   logic [2:0] req_op = '0;
   logic [31:0] req_a = '0, req_b = '0, resp_result;
   logic [4:0] req_tag = '0, resp_tag;
   int n_checks = 0, n_fail = 0;

   // reference reuse-cache state
   logic cv = 1'b0, cu = 1'b0;
   logic [31:0] ca = '0, cb = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(32), .MUL_LATENCY(2), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
      .resp_tag(resp_tag), .busy(busy));

   function automatic logic [31:0] ref_res(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         default: begin
            if (b == 32'h0) return op[1] ? a : 32'hFFFFFFFF;
            if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'h0 : a;
            if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
            return op[1] ? a % b : a / b;
         end
      endcase
   endfunction

   function automatic int exp_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
      if (!op[2]) return 2;
`ifdef MULDIV_DIV_REUSE_EN
      if (cv && a == ca && b == cb && op[0] == cu) return 1;
`endif
      if (b == 32'h0) return 1;
      if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
      return 33;
   endfunction

   // Issues one op at a negedge, waits for the response, consumes it; returns at a negedge in IDLE.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output int lat, output logic [31:0] res,
                        output logic [4:0] rtag, output logic rdy, output int elat,
                        output logic [31:0] eres);
      elat = exp_lat(op, a, b);
      eres = ref_res(op, a, b);
      rdy = req_ready;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk); req_valid = 1'b0; lat++;
      end while (!resp_valid && lat < 100);
      lat = lat - 1;
      res = resp_result; rtag = resp_tag;
      if (op[2]) begin cv = 1'b1; ca = a; cb = b; cu = op[0]; end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks += 2;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_rst: ready=%b busy=%b expected 1 0", req_ready, busy);
      end
      if (resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid_in_rst: got %b expected 0", resp_valid);
      end
      rst = 1'b0; cv = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ctrl: ready=%b busy=%b valid=%b expected 1 0 0", req_ready, busy, resp_valid);
      end
      if (resp_result !== 32'h0) begin
         n_fail++; $display("FAIL reset_result: got %h expected 00000000", resp_result);
      end
      if (resp_tag !== 5'h0) begin
         n_fail++; $display("FAIL reset_tag: got %h expected 00", resp_tag);
      end
   endtask

   task automatic test_mul();
      logic [2:0]  ops[4] = '{3'd0, 3'd3, 3'd1, 3'd2};
      logic [31:0] as[4]  = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      logic [31:0] bs[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd2};
      logic [31:0] rs[4]  = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h40000000, 32'hFFFFFFFF};
      int lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      for (int i = 0; i < 4; i++) begin
         do_op(ops[i], as[i], bs[i], 5'(i + 1), lat, res, rtag, rdy, elat, eres);
         n_checks += 3;
         if (lat !== 2) begin n_fail++; $display("FAIL mul_lat[%0d]: got %0d expected 2", i, lat); end
         if (res !== rs[i]) begin n_fail++; $display("FAIL mul_res[%0d]: got %h expected %h", i, res, rs[i]); end
         if (rtag !== 5'(i + 1)) begin n_fail++; $display("FAIL mul_tag[%0d]: got %h expected %h", i, rtag, 5'(i + 1)); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops[6] = '{3'd4, 3'd6, 3'd7, 3'd5, 3'd4, 3'd6};
      logic [31:0] as[6]  = '{32'hFFFFFFEC, 32'hFFFFFFEC, 32'd20, 32'd100, 32'd7, 32'd7};
      logic [31:0] bs[6]  = '{32'd3, 32'd3, 32'd3, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
      logic [31:0] rs[6]  = '{32'hFFFFFFFA, 32'hFFFFFFFE, 32'd2, 32'd14, 32'hFFFFFFFD, 32'd1};
      int lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], as[i], bs[i], 5'(i + 8), lat, res, rtag, rdy, elat, eres);
         n_checks += 2;
         if (lat !== elat) begin n_fail++; $display("FAIL div_lat[%0d]: got %0d expected %0d", i, lat, elat); end
         if (res !== rs[i]) begin n_fail++; $display("FAIL div_res[%0d]: got %h expected %h", i, res, rs[i]); end
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops[5] = '{3'd5, 3'd6, 3'd4, 3'd4, 3'd6};
      logic [31:0] as[5]  = '{32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF7, 32'hFFFFFFF7};
      logic [31:0] bs[5]  = '{32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
      logic [31:0] rs[5]  = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF7};
      int lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], 5'(i + 16), lat, res, rtag, rdy, elat, eres);
         n_checks += 2;
         if (lat !== 1) begin n_fail++; $display("FAIL special_lat[%0d]: got %0d expected 1", i, lat); end
         if (res !== rs[i]) begin n_fail++; $display("FAIL special_res[%0d]: got %h expected %h", i, res, rs[i]); end
      end
   endtask

   task automatic test_hold_back_to_back();
      int n, lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'd5; req_b = 32'd6; req_tag = 5'd9;
      @(posedge clk);
      n = 0;
      do begin @(negedge clk); req_valid = 1'b0; n++; end while (!resp_valid && n < 20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks += 2;
         if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL hold_ctrl[%0d]: valid=%b ready=%b expected 1 0", i, resp_valid, req_ready);
         end
         if (resp_result !== 32'd30 || resp_tag !== 5'd9) begin
            n_fail++; $display("FAIL hold_data[%0d]: got %h/%h expected 0000001e/09", i, resp_result, resp_tag);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL hold_release: ready=%b valid=%b expected 1 0", req_ready, resp_valid);
      end
      do_op(3'd0, 32'd3, 32'd4, 5'd30, lat, res, rtag, rdy, elat, eres);
      n_checks += 2;
      if (rdy !== 1'b1 || lat !== 2) begin
         n_fail++; $display("FAIL b2b_accept: ready=%b lat=%0d expected 1 2", rdy, lat);
      end
      if (res !== 32'd12 || rtag !== 5'd30) begin
         n_fail++; $display("FAIL b2b_res: got %h/%h expected 0000000c/1e", res, rtag);
      end
   endtask

   task automatic test_flush();
      int seen, lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      req_valid = 1'b1; req_op = 3'd4; req_a = 32'hFFFFFF9C; req_b = 32'd7; req_tag = 5'd4;
      @(posedge clk);
      repeat (10) begin @(negedge clk); req_valid = 1'b0; end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; cv = 1'b0;
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL flush_idle: ready=%b busy=%b expected 1 0", req_ready, busy);
      end
      seen = 0;
      repeat (40) begin @(negedge clk); if (resp_valid) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL flush_no_resp: valid cycles %0d expected 0", seen); end
      req_valid = 1'b1; flush = 1'b1; req_op = 3'd0;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: busy=%b expected 0", busy); end
      do_op(3'd0, 32'd3, 32'd4, 5'd17, lat, res, rtag, rdy, elat, eres);
      n_checks++;
      if (res !== 32'd12 || rtag !== 5'd17 || lat !== 2) begin
         n_fail++; $display("FAIL flush_after_mul: got %h/%h lat %0d expected 0000000c/11 lat 2", res, rtag, lat);
      end
   endtask

   task automatic test_reset_mid();
      int seen, lat, elat; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
      req_valid = 1'b1; req_op = 3'd0; req_a = 32'd9; req_b = 32'd9; req_tag = 5'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_tag !== 5'd0) begin
         n_fail++; $display("FAIL rst_mid: ready=%b valid=%b tag=%h expected 1 0 00", req_ready, resp_valid, resp_tag);
      end
      @(negedge clk);
      rst = 1'b0; cv = 1'b0;
      seen = 0;
      repeat (4) begin @(negedge clk); if (resp_valid) seen++; end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL rst_no_resp: valid cycles %0d expected 0", seen); end
      do_op(3'd0, 32'd3, 32'd4, 5'd21, lat, res, rtag, rdy, elat, eres);
      n_checks++;
      if (res !== 32'd12 || rtag !== 5'd21) begin
         n_fail++; $display("FAIL rst_after_mul: got %h/%h expected 0000000c/15", res, rtag);
      end
   endtask

   task automatic test_reuse();
      int lat, elat, l2; logic [31:0] res, eres; logic [4:0] rtag; logic rdy;
`ifdef MULDIV_DIV_REUSE_EN
      l2 = 1;
`else
      l2 = 33;
`endif
      flush = 1'b1; @(negedge clk); flush = 1'b0; cv = 1'b0;
      do_op(3'd4, 32'd100, 32'd7, 5'd1, lat, res, rtag, rdy, elat, eres);
      n_checks++;
      if (lat !== 33 || res !== 32'd14) begin
         n_fail++; $display("FAIL reuse_div: lat %0d res %h expected 33 0000000e", lat, res);
      end
      do_op(3'd6, 32'd100, 32'd7, 5'd2, lat, res, rtag, rdy, elat, eres);
      n_checks++;
      if (lat !== l2 || res !== 32'd2) begin
         n_fail++; $display("FAIL reuse_rem: lat %0d res %h expected %0d 00000002", lat, res, l2);
      end
      do_op(3'd4, 32'd100, 32'd7, 5'd3, lat, res, rtag, rdy, elat, eres);
      flush = 1'b1; @(negedge clk); flush = 1'b0; cv = 1'b0;
      do_op(3'd6, 32'd100, 32'd7, 5'd4, lat, res, rtag, rdy, elat, eres);
      n_checks++;
      if (lat !== 33 || res !== 32'd2) begin
         n_fail++; $display("FAIL reuse_flushed: lat %0d res %h expected 33 00000002", lat, res);
      end
   endtask

   task automatic test_random();
      int lat, elat; logic [31:0] res, eres, a, b; logic [4:0] rtag, tag; logic rdy; logic [2:0] op;
      a = 32'd1; b = 32'd1;
      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(0, 7));
         tag = 5'($urandom);
         case ($urandom_range(0, 9))
            0: begin a = $urandom; b = 32'h0; end
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: begin a = $urandom; b = 32'($urandom_range(1, 15)); end
            3: ;
            default: begin a = $urandom; b = $urandom; end
         endcase
         do_op(op, a, b, tag, lat, res, rtag, rdy, elat, eres);
         n_checks += 3;
         if (lat !== elat) begin n_fail++; $display("FAIL rand_lat[%0d] op%0d: got %0d expected %0d", i, op, lat, elat); end
         if (res !== eres) begin n_fail++; $display("FAIL rand_res[%0d] op%0d a=%h b=%h: got %h expected %h", i, op, a, b, res, eres); end
         if (rtag !== tag) begin n_fail++; $display("FAIL rand_tag[%0d]: got %h expected %h", i, rtag, tag); end
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_hold_back_to_back();
      test_flush();
      test_reset_mid();
      test_reuse();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
